// File: rtl/bg_render_pkg.sv
// Shared constants, colour type and fixed 16-entry palette for the scrolling background renderer.
package bg_render_pkg;

    localparam int BG_SRC_W     = 320;
    localparam int BG_SRC_H     = 240;
    localparam int BG_IDX_BITS  = 4;
    localparam int BG_COL_BITS  = 4;
    localparam int BG_PIPE_LAT  = 3;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } bg_rgb12_t;

    function automatic bg_rgb12_t bg_palette12(input logic [3:0] idx);
        bg_rgb12_t c;
        case (idx)
            4'd0:    c = 12'h000;
            4'd1:    c = 12'h00A;
            4'd2:    c = 12'h0A0;
            4'd3:    c = 12'h0AA;
            4'd4:    c = 12'hA00;
            4'd5:    c = 12'hA0A;
            4'd6:    c = 12'hA50;
            4'd7:    c = 12'hAAA;
            4'd8:    c = 12'h555;
            4'd9:    c = 12'h55F;
            4'd10:   c = 12'h5F5;
            4'd11:   c = 12'h5FF;
            4'd12:   c = 12'hF55;
            4'd13:   c = 12'hF5F;
            4'd14:   c = 12'hFF5;
            4'd15:   c = 12'hFFF;
            default: c = 12'h000;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/bg_palette_lut.sv
// Combinational palette index to RGB lookup; the parent registers the result.
module bg_palette_lut
    import bg_render_pkg::*;
#(
    parameter int IDX_BITS = BG_IDX_BITS,
    parameter int COL_BITS = BG_COL_BITS
) (
    input  logic [IDX_BITS-1:0] idx,
    output logic [COL_BITS-1:0] red,
    output logic [COL_BITS-1:0] green,
    output logic [COL_BITS-1:0] blue
);

    logic [31:0] idx_wide_s;
    bg_rgb12_t   col_s;

    // Indices beyond the 16-entry table render white
    always_comb begin
        idx_wide_s = 32'(idx);
        if (idx_wide_s < 32'd16) begin
            col_s = bg_palette12(4'(idx));
        end else begin
            col_s = bg_rgb12_t'(12'hFFF);
        end
        red   = COL_BITS'(col_s.r);
        green = COL_BITS'(col_s.g);
        blue  = COL_BITS'(col_s.b);
    end

endmodule

// File: rtl/bg_scroll_renderer.sv
// Scrolling, downscaled background renderer: coordinate wrap, ROM address, palette stage.
// Optional macro BG_SCROLL_TRANSP_EN adds a transp output and renders index 0 as transparent.
module bg_scroll_renderer
    import bg_render_pkg::*;
#(
    parameter int SRC_W       = BG_SRC_W,
    parameter int SRC_H       = BG_SRC_H,
    parameter int SCALE_SHIFT = 1,
    parameter int IDX_BITS    = BG_IDX_BITS,
    parameter int COL_BITS    = BG_COL_BITS
) (
    input  logic                               vga_clk,
    input  logic                               reset_n,
    input  logic [9:0]                         DrawX,
    input  logic [9:0]                         DrawY,
    input  logic                               blank,
    input  logic [9:0]                         scroll_x,
    input  logic [9:0]                         scroll_y,
    input  logic                               scroll_we,
    output logic [$clog2(SRC_W*SRC_H)-1:0]     rom_addr,
    input  logic [IDX_BITS-1:0]                rom_q,
    output logic [COL_BITS-1:0]                red,
    output logic [COL_BITS-1:0]                green,
    output logic [COL_BITS-1:0]                blue,
    output logic                               scroll_err
`ifdef BG_SCROLL_TRANSP_EN
    ,
    output logic                               transp
`endif
);

    localparam int         ADDR_W   = $clog2(SRC_W*SRC_H);
    localparam logic [10:0] SRC_W_11 = 11'(SRC_W);
    localparam logic [10:0] SRC_H_11 = 11'(SRC_H);
    localparam logic [9:0]  SRC_W_10 = 10'(SRC_W);
    localparam logic [9:0]  SRC_H_10 = 10'(SRC_H);

    logic                frame_start_s;
    logic                take_pend_s;
    logic                wr_ok_s;
    logic                wr_bad_s;
    logic [9:0]          eff_x_s;
    logic [9:0]          eff_y_s;
    logic [10:0]         sum_x_s;
    logic [10:0]         sum_y_s;
    logic [10:0]         sx_s;
    logic [10:0]         sy_s;
    logic [ADDR_W-1:0]   addr_s;
    logic                vis_s;

    logic [9:0]          cur_x_r;
    logic [9:0]          cur_y_r;
    logic [9:0]          pend_x_r;
    logic [9:0]          pend_y_r;
    logic                pend_v_r;
    logic                err_r;
    logic [ADDR_W-1:0]   rom_addr_r;
    logic [1:0]          blank_d_r;
    logic [COL_BITS-1:0] red_r;
    logic [COL_BITS-1:0] green_r;
    logic [COL_BITS-1:0] blue_r;
    logic [COL_BITS-1:0] lut_red_s;
    logic [COL_BITS-1:0] lut_green_s;
    logic [COL_BITS-1:0] lut_blue_s;

    // Scroll write qualification and source coordinate wrap (one compare-subtract per axis)
    always_comb begin
        frame_start_s = (DrawX == 10'd0) && (DrawY == 10'd0);
        take_pend_s   = frame_start_s && pend_v_r;
        wr_ok_s       = scroll_we && (scroll_x < SRC_W_10) && (scroll_y < SRC_H_10);
        wr_bad_s      = scroll_we && !wr_ok_s;
        // The frame-start pixel already uses the newly committed offset
        eff_x_s       = take_pend_s ? pend_x_r : cur_x_r;
        eff_y_s       = take_pend_s ? pend_y_r : cur_y_r;
        sum_x_s       = {1'b0, DrawX >> SCALE_SHIFT} + {1'b0, eff_x_s};
        sum_y_s       = {1'b0, DrawY >> SCALE_SHIFT} + {1'b0, eff_y_s};
        if (sum_x_s >= SRC_W_11) begin
            sx_s = sum_x_s - SRC_W_11;
        end else begin
            sx_s = sum_x_s;
        end
        if (sum_y_s >= SRC_H_11) begin
            sy_s = sum_y_s - SRC_H_11;
        end else begin
            sy_s = sum_y_s;
        end
        addr_s = ADDR_W'(32'(sy_s) * 32'(SRC_W) + 32'(sx_s));
    end

    // Pending/current scroll registers and sticky error flag
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_x_r  <= 10'd0;
            cur_y_r  <= 10'd0;
            pend_x_r <= 10'd0;
            pend_y_r <= 10'd0;
            pend_v_r <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            if (take_pend_s) begin
                cur_x_r <= pend_x_r;
                cur_y_r <= pend_y_r;
            end
            // A write on the frame-start cycle is held for the following frame
            if (wr_ok_s) begin
                pend_x_r <= scroll_x;
                pend_y_r <= scroll_y;
                pend_v_r <= 1'b1;
            end else if (frame_start_s) begin
                pend_v_r <= 1'b0;
            end
            if (wr_bad_s) begin
                err_r <= 1'b1;
            end
        end
    end

    bg_palette_lut #(
        .IDX_BITS (IDX_BITS),
        .COL_BITS (COL_BITS)
    ) u_lut (
        .idx   (rom_q),
        .red   (lut_red_s),
        .green (lut_green_s),
        .blue  (lut_blue_s)
    );

    // Pixel visibility at the palette stage
    always_comb begin
`ifdef BG_SCROLL_TRANSP_EN
        vis_s = blank_d_r[1] && (rom_q != {IDX_BITS{1'b0}});
`else
        vis_s = blank_d_r[1];
`endif
    end

    // S1 address, blank delay; S3 palette colour (the third blank stage is the gated RGB register)
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_addr_r <= {ADDR_W{1'b0}};
            blank_d_r  <= 2'b00;
            red_r      <= {COL_BITS{1'b0}};
            green_r    <= {COL_BITS{1'b0}};
            blue_r     <= {COL_BITS{1'b0}};
        end else begin
            rom_addr_r <= addr_s;
            blank_d_r  <= {blank_d_r[0], blank};
            if (vis_s) begin
                red_r   <= lut_red_s;
                green_r <= lut_green_s;
                blue_r  <= lut_blue_s;
            end else begin
                red_r   <= {COL_BITS{1'b0}};
                green_r <= {COL_BITS{1'b0}};
                blue_r  <= {COL_BITS{1'b0}};
            end
        end
    end

`ifdef BG_SCROLL_TRANSP_EN
    logic transp_r;

    // Transparent flag aligned with the RGB register
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            transp_r <= 1'b0;
        end else begin
            transp_r <= blank_d_r[1] && (rom_q == {IDX_BITS{1'b0}});
        end
    end

    assign transp = transp_r;
`endif

    assign rom_addr   = rom_addr_r;
    assign red        = red_r;
    assign green      = green_r;
    assign blue       = blue_r;
    assign scroll_err = err_r;

endmodule
